// File: rtl/mux_bus_demux4_if.sv
// Shared-bus beat input, pair output handshake and status for mux_bus_demux4.
// slave is the demux side, master is the side feeding beats and taking pairs.
interface mux_bus_demux4_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             S;
   logic [WIDTH-1:0] F;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] A_out;
   logic [WIDTH-1:0] B_out;
   logic [CNT_W-1:0] pair_cnt;
   logic             order_err;

   modport slave (
      input  in_valid, S, F, out_ready,
      output in_ready, out_valid, A_out, B_out, pair_cnt, order_err
   );

   modport master (
      output in_valid, S, F, out_ready,
      input  in_ready, out_valid, A_out, B_out, pair_cnt, order_err
   );
endinterface

// File: rtl/mux_bus_demux4.sv
// Re-assembles S-tagged beats on shared bus F into registered A/B pairs; DEMUX_ORDER_CHECK_EN enforces A-then-B.
// Latency: pair valid the cycle after the completing beat is accepted; no combinational path from F/S.
// Backpressure: in_ready drops while a pair is held; the pair stays stable until out_ready.
module mux_bus_demux4 #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input logic              clk,
   input logic              rst_n,
   mux_bus_demux4_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GOT_A = 2'd1,
      FULL  = 2'd2,
      GOT_B = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             accept;

   assign accept = bus.in_valid && (state_q != FULL);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!bus.S) begin
                  a_d     = bus.F;
                  state_d = GOT_A;
               end else begin
`ifdef DEMUX_ORDER_CHECK_EN
                  err_d   = 1'b1;
`else
                  b_d     = bus.F;
                  state_d = GOT_B;
`endif
               end
            end
         end
         GOT_A: begin
            if (accept) begin
               if (bus.S) begin
                  b_d     = bus.F;
                  state_d = FULL;
               end else begin
                  // newest A replaces the held one
                  a_d     = bus.F;
`ifdef DEMUX_ORDER_CHECK_EN
                  err_d   = 1'b1;
`endif
               end
            end
         end
`ifndef DEMUX_ORDER_CHECK_EN
         GOT_B: begin
            if (accept) begin
               if (!bus.S) begin
                  a_d     = bus.F;
                  state_d = FULL;
               end else begin
                  b_d     = bus.F;
               end
            end
         end
`endif
         FULL: begin
            if (bus.out_ready) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q != FULL);
   assign bus.out_valid = (state_q == FULL);
   assign bus.A_out     = a_q;
   assign bus.B_out     = b_q;
   assign bus.pair_cnt  = cnt_q;
   assign bus.order_err = err_q;
endmodule

// File: tb/tb_mux_bus_demux4.sv
// Directed bench for mux_bus_demux4: expected pairs queued when the completing beat is driven,
// popped and compared when the output handshake fires.
module tb_mux_bus_demux4;
   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
   } pair_t;

   logic  clk = 1'b0;
   logic  rst_n;
   int    n_tests = 0;
   int    n_fail  = 0;
   int    hs_cnt  = 0;
   int    exp_cnt = 0;
   pair_t sb[$];

   mux_bus_demux4_if #(.WIDTH(4), .CNT_W(8)) bus ();

   mux_bus_demux4 #(.WIDTH(4), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare any output handshake happening at the coming edge, then advance one cycle.
   task automatic cyc();
      pair_t p;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         hs_cnt++;
         n_tests++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_empty: observed pair A=%0h B=%0h expected no output", bus.A_out, bus.B_out);
         end
         if (sb.size() != 0) begin
            p = sb.pop_front();
            chk("pair_a", 32'(bus.A_out), 32'(p.a));
            chk("pair_b", 32'(bus.B_out), 32'(p.b));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic s, input logic [3:0] f);
      bus.in_valid = 1'b1;
      bus.S        = s;
      bus.F        = f;
      cyc();
      bus.in_valid = 1'b0;
   endtask

   task automatic push(input logic [3:0] a, input logic [3:0] b);
      pair_t p;
      p.a = a;
      p.b = b;
      sb.push_back(p);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.S         = 1'b0;
      bus.F         = 4'h0;
      bus.out_ready = 1'b0;
      repeat (2) cyc();
      rst_n = 1'b1;

      chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_a",         32'(bus.A_out), 32'd0);
      chk("rst_b",         32'(bus.B_out), 32'd0);
      chk("rst_cnt",       32'(bus.pair_cnt), 32'd0);
      chk("rst_err",       32'(bus.order_err), 32'd0);

      // reset while holding A, beats offered during reset are discarded
      beat(1'b0, 4'h1);
      chk("mid_a_held", 32'(bus.A_out), 32'h1);
      rst_n = 1'b0;
      bus.in_valid = 1'b1; bus.S = 1'b0; bus.F = 4'hF;
      cyc();
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      chk("mid_rst_a",         32'(bus.A_out), 32'd0);
      chk("mid_rst_in_ready",  32'(bus.in_ready), 32'd1);
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);

      // reset while FULL drops the pair without counting it
      beat(1'b0, 4'h1);
      beat(1'b1, 4'h3);
      chk("full_before_rst", 32'(bus.out_valid), 32'd1);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("full_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("full_rst_cnt",       32'(bus.pair_cnt), 32'd0);
      chk("full_rst_b",         32'(bus.B_out), 32'd0);

      // basic pair with out_ready held high
      bus.out_ready = 1'b1;
      beat(1'b0, 4'b0001);
      chk("basic_not_valid", 32'(bus.out_valid), 32'd0);
      push(4'b0001, 4'b0011);
      beat(1'b1, 4'b0011);
      chk("basic_valid", 32'(bus.out_valid), 32'd1);
      chk("basic_in_ready_low", 32'(bus.in_ready), 32'd0);
      cyc();
      exp_cnt++;
      chk("basic_valid_one_cycle", 32'(bus.out_valid), 32'd0);
      chk("basic_in_ready", 32'(bus.in_ready), 32'd1);
      chk("basic_cnt", 32'(bus.pair_cnt), 32'(exp_cnt));

      // backpressure: stalled pair stays put, a beat offered meanwhile is ignored
      bus.out_ready = 1'b0;
      beat(1'b0, 4'b0010);
      push(4'b0010, 4'b0110);
      beat(1'b1, 4'b0110);
      bus.in_valid = 1'b1; bus.S = 1'b0; bus.F = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready",  32'(bus.in_ready), 32'd0);
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_a",         32'(bus.A_out), 32'b0010);
         chk("bp_b",         32'(bus.B_out), 32'b0110);
         chk("bp_cnt",       32'(bus.pair_cnt), 32'(exp_cnt));
         chk("bp_err",       32'(bus.order_err), 32'd0);
         cyc();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      cyc();
      exp_cnt++;
      chk("bp_cnt_after", 32'(bus.pair_cnt), 32'(exp_cnt));
      chk("bp_a_kept",    32'(bus.A_out), 32'b0010);
      chk("bp_out_valid_after", 32'(bus.out_valid), 32'd0);

      // newest A wins
      beat(1'b0, 4'b1001);
      chk("ow_err_first", 32'(bus.order_err), 32'd0);
      beat(1'b0, 4'b1011);
`ifdef DEMUX_ORDER_CHECK_EN
      chk("ow_err_pulse", 32'(bus.order_err), 32'd1);
`else
      chk("ow_err_pulse", 32'(bus.order_err), 32'd0);
`endif
      push(4'b1011, 4'b0101);
      beat(1'b1, 4'b0101);
      chk("ow_err_cleared", 32'(bus.order_err), 32'd0);
      cyc();
      exp_cnt++;
      chk("ow_cnt", 32'(bus.pair_cnt), 32'(exp_cnt));

      // B-first ordering
      beat(1'b1, 4'b0111);
      chk("bf_out_valid_1", 32'(bus.out_valid), 32'd0);
`ifdef DEMUX_ORDER_CHECK_EN
      chk("bf_err", 32'(bus.order_err), 32'd1);
      chk("bf_b_dropped", 32'(bus.B_out), 32'b0101);
      beat(1'b0, 4'b1011);
      chk("bf_err_cleared", 32'(bus.order_err), 32'd0);
      chk("bf_got_a", 32'(bus.out_valid), 32'd0);
      push(4'b1011, 4'b0100);
      beat(1'b1, 4'b0100);
      chk("bf_valid", 32'(bus.out_valid), 32'd1);
      cyc();
      exp_cnt++;
`else
      chk("bf_err", 32'(bus.order_err), 32'd0);
      push(4'b1011, 4'b0111);
      beat(1'b0, 4'b1011);
      chk("bf_valid", 32'(bus.out_valid), 32'd1);
      chk("bf_err_2", 32'(bus.order_err), 32'd0);
      cyc();
      exp_cnt++;
      // B overwrite while waiting for A
      beat(1'b1, 4'h1);
      beat(1'b1, 4'h2);
      chk("bow_not_valid", 32'(bus.out_valid), 32'd0);
      push(4'h3, 4'h2);
      beat(1'b0, 4'h3);
      cyc();
      exp_cnt++;
`endif
      chk("bf_cnt", 32'(bus.pair_cnt), 32'(exp_cnt));

      // 256 back-to-back 3-cycle pairs wrap the counter to zero
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("wrap_start_cnt", 32'(bus.pair_cnt), 32'd0);
      hs_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         logic [3:0] av;
         av = 4'(i);
         beat(1'b0, av);
         push(av, ~av);
         beat(1'b1, ~av);
         cyc();
         if (i == 254) chk("wrap_cnt_255", 32'(bus.pair_cnt), 32'hFF);
      end
      chk("wrap_cnt_zero", 32'(bus.pair_cnt), 32'd0);
      chk("wrap_pulses", 32'(hs_cnt), 32'd256);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
